// File: rtl/cmac_bp_reader_pkg.sv
// Shared definitions for the CMAC backpressure-event reader: register byte
// offsets, AXI response codes and the pop pulser state encoding.
package cmac_bp_reader_pkg;

    // Register byte offsets; only bits [4:2] are decoded on the bus
    localparam logic [4:0] REG_STATUS    = 5'h00;
    localparam logic [4:0] REG_LENGTH    = 5'h04;
    localparam logic [4:0] REG_TS_LO     = 5'h08;
    localparam logic [4:0] REG_TS_HI     = 5'h0C;
    localparam logic [4:0] REG_POP       = 5'h10;
    localparam logic [4:0] REG_POP_COUNT = 5'h14;
    localparam logic [4:0] REG_IRQ_EN    = 5'h18;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HIGH   = 2'd1,
        SETTLE = 2'd2
    } pop_state_e;

    // Turns a decoded word index back into a byte offset for comparison
    function automatic logic [4:0] reg_offset(input logic [2:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/bp_pop_pulser.sv
// Pop pulser: turns a single-cycle pop request into a clean, flop-driven
// fifo_next pulse of PULSE_CYCLES cycles, followed by a SETTLE_CYCLES quiet
// period so the monitor's head registers can update before the next pop.
module bp_pop_pulser
    import cmac_bp_reader_pkg::*;
#(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic pop_req,
    output logic busy,
    output logic fifo_next
);

    localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    pop_state_e state;
    pop_state_e state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       fifo_next_nxt;

    // State, counter and the glitch-free fifo_next flop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            fifo_next <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            fifo_next <= fifo_next_nxt;
        end
    end

    // Next state: requests outside IDLE are simply ignored
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pop_req) begin
                    state_nxt = HIGH;
                    cnt_nxt   = PULSE_LOAD;
                end
            end
            HIGH: begin
                if (cnt == 4'd0) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs: busy from current state, fifo_next registered from next state
    always_comb begin
        busy          = (state != IDLE);
        fifo_next_nxt = (state_nxt == HIGH);
    end

endmodule

// File: rtl/cmac_bp_event_reader.sv
// AXI4-Lite front-end that exposes the head of the CMAC backpressure-event
// FIFO to software and converts a POP register write into a fifo_next pulse.
// Optional macro CMAC_BP_READER_IRQ_EN adds the IRQ_EN register at 0x18 and
// a registered irq output raised while an event is ready to be read.
module cmac_bp_event_reader
    import cmac_bp_reader_pkg::*;
#(
    parameter int AW            = 32,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [31:0]   fifo_bp_length,
    input  logic          fifo_bp_rxad,
    input  logic [63:0]   fifo_bp_ts,
    input  logic          fifo_valid,
    output logic          fifo_next,
`ifdef CMAC_BP_READER_IRQ_EN
    output logic          irq,
`endif
    input  logic [AW-1:0] s_axi_awaddr,
    input  logic          s_axi_awvalid,
    output logic          s_axi_awready,
    input  logic [31:0]   s_axi_wdata,
    input  logic [3:0]    s_axi_wstrb,
    input  logic          s_axi_wvalid,
    output logic          s_axi_wready,
    output logic [1:0]    s_axi_bresp,
    output logic          s_axi_bvalid,
    input  logic          s_axi_bready,
    input  logic [AW-1:0] s_axi_araddr,
    input  logic          s_axi_arvalid,
    output logic          s_axi_arready,
    output logic [31:0]   s_axi_rdata,
    output logic [1:0]    s_axi_rresp,
    output logic          s_axi_rvalid,
    input  logic          s_axi_rready
);

    logic        active;
    logic        aw_done;
    logic        w_done;
    logic [2:0]  aw_idx;
    logic [31:0] wdata_q;
    logic        wr_exec;
    logic        pop_wr;
    logic        pop_req;
    logic [1:0]  wr_resp;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        busy;
    logic [31:0] pop_count;
    logic [31:0] ts_hi_snap;
`ifdef CMAC_BP_READER_IRQ_EN
    logic        irq_en;
    logic        irq_en_we;
`endif

    // Address bits outside [4:2], byte strobes and spare data bits are unused
    logic unused_bits;
    assign unused_bits = ^{s_axi_awaddr[AW-1:5], s_axi_awaddr[1:0],
                           s_axi_araddr[AW-1:5], s_axi_araddr[1:0],
                           s_axi_wstrb, wdata_q};

    // Ready signals are held low until the first clock after reset release
    assign s_axi_awready = active & ~aw_done & ~s_axi_bvalid;
    assign s_axi_wready  = active & ~w_done & ~s_axi_bvalid;
    assign s_axi_arready = active & ~s_axi_rvalid;
    assign wr_exec       = aw_done & w_done & ~s_axi_bvalid;
    assign pop_req       = wr_exec & pop_wr;

    // Write decode: only POP (and IRQ_EN when built in) are writable
    always_comb begin
        wr_resp = RESP_SLVERR;
        pop_wr  = 1'b0;
`ifdef CMAC_BP_READER_IRQ_EN
        irq_en_we = 1'b0;
`endif
        case (reg_offset(aw_idx))
            REG_POP: begin
                wr_resp = RESP_OKAY;
                pop_wr  = 1'b1;
            end
            REG_IRQ_EN: begin
`ifdef CMAC_BP_READER_IRQ_EN
                wr_resp   = RESP_OKAY;
                irq_en_we = wr_exec;
`else
                wr_resp   = RESP_SLVERR;
`endif
            end
            default: wr_resp = RESP_SLVERR;
        endcase
    end

    // Read decode; STATUS reflects the pulser state before any same-cycle pop
    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (reg_offset(s_axi_araddr[4:2]))
            REG_STATUS:    rd_data = {29'd0, busy, fifo_bp_rxad, fifo_valid & ~busy};
            REG_LENGTH:    rd_data = fifo_bp_length;
            REG_TS_LO:     rd_data = fifo_bp_ts[31:0];
            REG_TS_HI:     rd_data = ts_hi_snap;
            REG_POP:       rd_data = '0;
            REG_POP_COUNT: rd_data = pop_count;
`ifdef CMAC_BP_READER_IRQ_EN
            REG_IRQ_EN:    rd_data = {31'd0, irq_en};
`endif
            default:       rd_resp = RESP_SLVERR;
        endcase
    end

    // Write channel: capture AW and W independently, execute once both are in
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            active       <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            aw_idx       <= '0;
            wdata_q      <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            active <= 1'b1;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_done <= 1'b1;
                aw_idx  <= s_axi_awaddr[4:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_done  <= 1'b1;
                wdata_q <= s_axi_wdata;
            end
            if (wr_exec) begin
                aw_done      <= 1'b0;
                w_done       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: one outstanding read, TS_LO reads snapshot the upper half
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            ts_hi_snap   <= '0;
        end else begin
            if (s_axi_arvalid && s_axi_arready) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_data;
                s_axi_rresp  <= rd_resp;
                if (reg_offset(s_axi_araddr[4:2]) == REG_TS_LO) begin
                    ts_hi_snap <= fifo_bp_ts[63:32];
                end
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Count only the pops the pulser actually turns into a pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pop_count <= '0;
        end else if (pop_req && !busy) begin
            pop_count <= pop_count + 32'd1;
        end
    end

`ifdef CMAC_BP_READER_IRQ_EN
    // Interrupt enable register and registered "event ready" interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (irq_en_we) begin
                irq_en <= wdata_q[0];
            end
            irq <= irq_en & fifo_valid & ~busy;
        end
    end
`endif

    bp_pop_pulser #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_pulser (
        .clk      (clk),
        .resetn   (resetn),
        .pop_req  (pop_req),
        .busy     (busy),
        .fifo_next(fifo_next)
    );

endmodule

// File: tb/tb_cmac_bp_event_reader.sv
// Self-checking bench for cmac_bp_event_reader: directed scenarios followed
// by randomized register traffic checked against a transaction-level model.
module tb_cmac_bp_event_reader;

    localparam int PULSE  = 2;
    localparam int SETTLE = 4;
    localparam int LIMIT  = 50;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] fifo_bp_length = '0;
    logic        fifo_bp_rxad = 1'b0;
    logic [63:0] fifo_bp_ts = '0;
    logic        fifo_valid = 1'b0;
    logic        fifo_next;
`ifdef CMAC_BP_READER_IRQ_EN
    logic        irq;
`endif
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    int total = 0;
    int bad = 0;

    // Reference model state, updated from the register rules only
    int          model_pops = 0;
    int          exp_rises = 0;
    logic [31:0] model_snap = '0;

    // fifo_next monitor
    int   rises = 0;
    int   cur_width = 0;
    int   last_width = 0;
    logic prev_next = 1'b0;

    cmac_bp_event_reader dut (
        .clk           (clk),
        .resetn        (resetn),
        .fifo_bp_length(fifo_bp_length),
        .fifo_bp_rxad  (fifo_bp_rxad),
        .fifo_bp_ts    (fifo_bp_ts),
        .fifo_valid    (fifo_valid),
        .fifo_next     (fifo_next),
`ifdef CMAC_BP_READER_IRQ_EN
        .irq           (irq),
`endif
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;

    // Track rising edges and high width of fifo_next
    always @(negedge clk) begin
        if (fifo_next && !prev_next) begin
            rises     = rises + 1;
            cur_width = 1;
        end else if (fifo_next) begin
            cur_width = cur_width + 1;
        end
        if (!fifo_next && prev_next) last_width = cur_width;
        prev_next = fifo_next;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total = total + 1;
        if (observed !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rxad,
                                 input logic [31:0] len, input logic [63:0] ts);
        fifo_valid     = valid;
        fifo_bp_rxad   = rxad;
        fifo_bp_length = len;
        fifo_bp_ts     = ts;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Both bus tasks are entered and left just after a falling clock edge
    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
        int   n;
        logic aw_hs;
        logic w_hs;
        n = 0;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = 4'($urandom);
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b1;
        while ((s_axi_awvalid || s_axi_wvalid) && n < LIMIT) begin
            aw_hs = s_axi_awvalid & s_axi_awready;
            w_hs  = s_axi_wvalid & s_axi_wready;
            @(negedge clk);
            n = n + 1;
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs) s_axi_wvalid = 1'b0;
        end
        while (!s_axi_bvalid && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= LIMIT) begin
            checkOutput("write_timeout", 64'(n), 64'(LIMIT - 1));
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
            s_axi_bready  = 1'b0;
            resp = 2'bxx;
        end else begin
            resp = s_axi_bresp;
            @(negedge clk);
            s_axi_bready = 1'b0;
        end
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        int n;
        n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b0;
        while (!s_axi_arready && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && n < LIMIT) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= LIMIT) begin
            checkOutput("read_timeout", 64'(n), 64'(LIMIT - 1));
            data = 'x;
            resp = 2'bxx;
        end else begin
            data = s_axi_rdata;
            resp = s_axi_rresp;
            s_axi_rready = 1'b1;
            @(negedge clk);
            s_axi_rready = 1'b0;
        end
    endtask

    // Reads one register and compares both data and response
    task automatic readCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        axiRead(addr, d, r);
        checkOutput({tag, "_data"}, 64'(d), 64'(exp_data));
        checkOutput({tag, "_resp"}, 64'(r), 64'(exp_resp));
    endtask

    logic [31:0] ro_offs [6] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h14, 32'h1C};

    initial begin
        logic [1:0]  resp;
        logic [31:0] word;
        logic [63:0] ts;
        int          base_rises;

        waitCycles(3);
        checkOutput("reset_fifo_next", 64'(fifo_next), 64'd0);
        checkOutput("reset_bvalid", 64'(s_axi_bvalid), 64'd0);
        checkOutput("reset_rvalid", 64'(s_axi_rvalid), 64'd0);
        checkOutput("reset_rdata", 64'(s_axi_rdata), 64'd0);
        checkOutput("reset_awready", 64'(s_axi_awready), 64'd0);
        checkOutput("reset_arready", 64'(s_axi_arready), 64'd0);
        resetn = 1'b1;
        waitCycles(2);

        $display("[TB] empty FIFO status");
        readCheck("status_empty", 32'h00, 32'h0, 2'b00);
        checkOutput("idle_fifo_next", 64'(fifo_next), 64'd0);
        readCheck("ts_hi_at_reset", 32'h0C, 32'h0, 2'b00);

        $display("[TB] head event registers");
        applyStimulus(1'b1, 1'b1, 32'h1234, 64'hAABBCCDD_11223344);
        waitCycles(1);
        readCheck("status_head", 32'h00, 32'h3, 2'b00);
        readCheck("length", 32'h04, 32'h1234, 2'b00);
        readCheck("ts_lo", 32'h08, 32'h11223344, 2'b00);
        model_snap = 32'hAABBCCDD;
        applyStimulus(1'b1, 1'b1, 32'h1234, 64'h55667788_11223344);
        readCheck("ts_hi_snapped", 32'h0C, model_snap, 2'b00);

        $display("[TB] pop pulse and dropped pop");
        base_rises = rises;
        axiWrite(32'h10, 32'h0, resp);
        model_pops = model_pops + 1;
        exp_rises  = exp_rises + 1;
        checkOutput("pop_resp", 64'(resp), 64'(2'b00));
        checkOutput("pulse_high", 64'(fifo_next), 64'd1);
        axiWrite(32'h10, 32'h0, resp);
        checkOutput("dropped_pop_resp", 64'(resp), 64'(2'b00));
        readCheck("status_busy", 32'h00, 32'h6, 2'b00);
        waitCycles(PULSE + SETTLE + 4);
        checkOutput("pulse_width", 64'(last_width), 64'(PULSE));
        checkOutput("single_pulse", 64'(rises - base_rises), 64'd1);
        readCheck("pop_count_one", 32'h14, 32'(model_pops), 2'b00);
        readCheck("status_settled", 32'h00, 32'h3, 2'b00);

        $display("[TB] read-only write and reserved read");
        axiWrite(32'h04, 32'hFFFF_FFFF, resp);
        checkOutput("ro_write_resp", 64'(resp), 64'(2'b10));
        readCheck("length_unchanged", 32'h04, 32'h1234, 2'b00);
        readCheck("rsvd_1c", 32'h1C, 32'h0, 2'b10);
`ifdef CMAC_BP_READER_IRQ_EN
        readCheck("irq_en_reset", 32'h18, 32'h0, 2'b00);
        axiWrite(32'h18, 32'h1, resp);
        checkOutput("irq_en_resp", 64'(resp), 64'(2'b00));
        waitCycles(2);
        checkOutput("irq_raised", 64'(irq), 64'd1);
        axiWrite(32'h18, 32'h0, resp);
        waitCycles(2);
        checkOutput("irq_cleared", 64'(irq), 64'd0);
`else
        readCheck("rsvd_18", 32'h18, 32'h0, 2'b10);
`endif

        $display("[TB] randomized traffic");
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    ts = {$urandom, $urandom};
                    applyStimulus(1'($urandom), 1'($urandom), $urandom, ts);
                    waitCycles(1);
                    readCheck("rnd_status", 32'h00,
                              {30'd0, fifo_bp_rxad, fifo_valid}, 2'b00);
                    readCheck("rnd_length", 32'h04, fifo_bp_length, 2'b00);
                    readCheck("rnd_ts_lo", 32'h08, ts[31:0], 2'b00);
                    model_snap = ts[63:32];
                    if ($urandom_range(0, 1) == 1) fifo_bp_ts[63:32] = $urandom;
                    readCheck("rnd_ts_hi", 32'h0C, model_snap, 2'b00);
                end
                1: begin
                    axiWrite(32'h10, $urandom, resp);
                    model_pops = model_pops + 1;
                    exp_rises  = exp_rises + 1;
                    checkOutput("rnd_pop_resp", 64'(resp), 64'(2'b00));
                    if ($urandom_range(0, 1) == 1) begin
                        axiWrite(32'h10, $urandom, resp);
                        checkOutput("rnd_drop_resp", 64'(resp), 64'(2'b00));
                    end
                    waitCycles(PULSE + SETTLE + 4);
                    readCheck("rnd_pop_count", 32'h14, 32'(model_pops), 2'b00);
                end
                2: begin
                    word = ro_offs[$urandom_range(0, 5)];
                    axiWrite(word, $urandom, resp);
                    checkOutput("rnd_ro_write", 64'(resp), 64'(2'b10));
                    readCheck("rnd_count_kept", 32'h14, 32'(model_pops), 2'b00);
                end
                default: begin
                    readCheck("rnd_rsvd_1c", 32'h1C, 32'h0, 2'b10);
`ifdef CMAC_BP_READER_IRQ_EN
                    readCheck("rnd_irq_en", 32'h18, 32'h0, 2'b00);
`else
                    readCheck("rnd_rsvd_18", 32'h18, 32'h0, 2'b10);
`endif
                end
            endcase
        end
        checkOutput("total_pulses", 64'(rises), 64'(exp_rises));

        $display("[TB] reset during pulse");
        axiWrite(32'h10, 32'h0, resp);
        exp_rises = exp_rises + 1;
        checkOutput("pre_reset_high", 64'(fifo_next), 64'd1);
        resetn = 1'b0;
        #1;
        checkOutput("async_reset_next", 64'(fifo_next), 64'd0);
        model_pops = 0;
        model_snap = '0;
        @(negedge clk);
        resetn = 1'b1;
        waitCycles(2);
        readCheck("pop_count_after_reset", 32'h14, 32'(model_pops), 2'b00);
        readCheck("ts_hi_after_reset", 32'h0C, model_snap, 2'b00);
        waitCycles(PULSE + SETTLE + 2);
        checkOutput("no_pulse_after_reset", 64'(rises), 64'(exp_rises));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmac_bp_event_reader.md
Name: cmac_bp_event_reader

Overview:
- AXI4-Lite register front-end that drains the backpressure-event FIFO produced by the CMAC backpressure monitor.
- Presents the head event (length, rx-alignment-dropped flag, 64-bit timestamp) as software-readable registers.
- Converts a software "pop" write into the clean rising-edge pulse on fifo_next that the monitor's edge detector requires.
- Sits between the monitor and the host AXI-Lite interconnect, in the same clock domain as the CMAC RX.

Parameters:
- AW, 32, AXI-Lite address width; only addr[4:2] is decoded.
- PULSE_CYCLES, 2, cycles fifo_next is held high per pop (legal range 1..15).
- SETTLE_CYCLES, 4, cycles after fifo_next falls before the head registers are reported valid again (legal range 1..15).

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- fifo_bp_length  in  32  head event length in cycles.
- fifo_bp_rxad  in  1  head event rx-alignment-dropped flag.
- fifo_bp_ts  in  64  head event timestamp.
- fifo_valid  in  1  head event present.
- fifo_next  out  1  pop strobe; the monitor pops on its rising edge.
- s_axi_awaddr/awvalid/awready  AW/1/1  write address channel.
- s_axi_wdata/wstrb/wvalid/wready  32/4/1/1  write data channel.
- s_axi_bresp/bvalid/bready  2/1/1  write response channel.
- s_axi_araddr/arvalid/arready  AW/1/1  read address channel.
- s_axi_rdata/rresp/rvalid/rready  32/2/1/1  read data channel.

Behaviour:
- Reset values (asynchronous, all outputs): fifo_next=0, awready=wready=arready=0, bvalid=rvalid=0, rdata=0, resp=0, pop_count=0, ts_hi_snap=0, pop FSM in IDLE.
- Register map, byte offsets:
  - 0x00 STATUS RO: bit0 = fifo_valid & (FSM==IDLE); bit1 = fifo_bp_rxad; bit2 = pop busy (FSM!=IDLE).
  - 0x04 LENGTH RO: fifo_bp_length.
  - 0x08 TS_LO RO: fifo_bp_ts[31:0]. Reading TS_LO also captures fifo_bp_ts[63:32] into ts_hi_snap in the same cycle.
  - 0x0C TS_HI RO: returns ts_hi_snap.
  - 0x10 POP WO: any write requests a pop.
  - 0x14 POP_COUNT RO: number of pulses issued. 32 bits, wraps at 2^32.
  - 0x18 and 0x1C return SLVERR with rdata=0; writes there are ignored with SLVERR.
- Writes:
  - AW and W are accepted independently; awready and wready are each high while that channel is not yet captured and bvalid=0.
  - The write executes in the cycle after both channels are captured; bvalid rises in that same cycle.
  - bvalid holds until bready. No new AW/W is accepted while bvalid=1.
  - Writes to read-only offsets return SLVERR (2'b10) and have no effect. A POP write returns OKAY.
  - wstrb is ignored.
- Reads:
  - arready is high when rvalid=0. A read accepted in cycle N presents rvalid/rdata in cycle N+1.
  - rdata and rresp hold until rready. One read is outstanding at most.
- Pop FSM:
  - IDLE: on a POP write -> HIGH, fifo_next=1, load the counter with PULSE_CYCLES-1, increment pop_count.
    - A POP while fifo_valid=0 is still pulsed and counted; the monitor ignores a pop on an empty FIFO.
  - HIGH: decrement; at 0 -> SETTLE, fifo_next=0, load SETTLE_CYCLES-1.
  - SETTLE: decrement; at 0 -> IDLE.
  - A POP write while not in IDLE is acknowledged OKAY but dropped, and pop_count is not incremented.
  - fifo_next is driven from a flop, with no glitch.
- A read and a write completing in the same cycle are both served. The POP side effect and the STATUS sample both use pre-write state.
- Reset mid-pulse forces fifo_next=0 immediately, because the reset is asynchronous.

Optional Feature:
- Macro CMAC_BP_READER_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) and register 0x18 IRQ_EN RW, where bit0 = enable, reset value 0.
  - irq is registered: irq = IRQ_EN[0] & fifo_valid & (FSM==IDLE).
  - Offset 0x18 becomes valid and returns OKAY.
- When undefined: no irq port, and 0x18 returns SLVERR.

Decomposition:
- Package cmac_bp_reader_pkg holds:
  - register offset constants (REG_STATUS ... REG_IRQ_EN);
  - RESP_OKAY and RESP_SLVERR;
  - the pop FSM state enum (IDLE, HIGH, SETTLE).
- One natural sub-module: bp_pop_pulser. It contains the pop FSM, counter and fifo_next flop. Its interface is pop_req in, busy and fifo_next out.

Test Plan:
- Reset, then read STATUS with fifo_valid=0 -> rdata=0x0, OKAY; fifo_next=0.
- Head event {rxad=1, length=0x1234, ts=0xAABBCCDD_11223344}: read STATUS/LENGTH/TS_LO/TS_HI -> 0x3, 0x1234, 0x11223344, 0xAABBCCDD.
- Change fifo_bp_ts[63:32] between the TS_LO and TS_HI reads -> TS_HI still returns the snapped value.
- POP write with defaults -> fifo_next high exactly 2 cycles; STATUS bit2=1 for 2+4 cycles; POP_COUNT=1.
- Second POP written during HIGH -> OKAY response, no extra pulse, POP_COUNT stays 1.
- Write to 0x04 and read from 0x1C -> both SLVERR; registers unchanged.
- Assert resetn=0 during HIGH -> fifo_next falls in the same cycle.
- Release reset -> POP_COUNT=0.
